fifo_width_downsizer: RTL



---
 rtl/fifo_width_downsizer.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_width_downsizer.sv
// rtl/fifo_width_downsizer.sv - serialises wide show-ahead FIFO words into narrow valid/ready beats
// One holding register, LS slice first; zero-bubble reload when the last beat handshakes.
module fifo_width_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] words_consumed,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
    $error("fifo_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t               r_state;
  logic [IN_WIDTH-1:0]  r_hold;
  logic [IDX_W-1:0]     r_idx;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0] r_words;

  logic             w_valid;
  logic             w_hs;
  logic             w_at_last;
  logic             w_load;
  logic [IDX_W-1:0] w_next_idx;

  assign w_valid    = (r_state == ST_FULL);
  assign w_hs       = w_valid & out_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_next_idx = r_idx + IDX_W'(1);
  // Gated by reset so no pop can be requested while the block is being cleared.
  assign w_load     = !reset & !fifo_empty & ((r_state == ST_EMPTY) | (w_hs & w_at_last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_hold     <= '0;
      r_idx      <= '0;
      r_out_data <= '0;
      r_words    <= '0;
    end else if (w_load) begin
      r_state    <= ST_FULL;
      r_hold     <= fifo_q;
      r_idx      <= '0;
      r_out_data <= fifo_q[OUT_WIDTH-1:0];
      r_words    <= r_words + CNT_WIDTH'(1);
    end else if (w_hs) begin
      if (w_at_last) begin
        r_state <= ST_EMPTY;
      end else begin
        r_idx      <= w_next_idx;
        r_out_data <= r_hold[OUT_WIDTH*int'(w_next_idx) +: OUT_WIDTH];
      end
    end
  end

  assign fifo_rdreq     = w_load;
  assign out_data       = r_out_data;
  assign out_valid      = w_valid;
  assign out_first      = w_valid & (r_idx == '0);
  assign out_last       = w_valid & w_at_last;
  assign busy           = w_valid;
  assign words_consumed = r_words;

endmodule
